start_token_srl_fifo: RTL and testbench

Control wrapper that turns a shift-register store into a first-word-fall-through FIFO. It carries start tokens from a producer task to a consumer PE task in the HLS dataflow region. Writes shift into the store; reads are served by an occupancy-derived read address. It owns the full/empty handshakes on both ends.

---
 rtl/start_token_srl_fifo_pkg.sv | 11 +
 rtl/start_token_srl_store.sv | 20 ++
 rtl/start_token_srl_fifo.sv | 55 +++++
 tb/tb_start_token_srl_fifo.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/start_token_srl_fifo_pkg.sv
// start_token_srl_fifo_pkg: shared sizing helpers for the start-token SRL FIFO
package start_token_srl_fifo_pkg;
  function automatic int clog2_min(input int n);
    int b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction
  function automatic bit depth_fits(input int depth, input int aw);
    return (depth >= 1) && (clog2_min(depth) <= aw);
  endfunction
endpackage

// File: rtl/start_token_srl_store.sv
// start_token_srl_store: shift-in, addressed-read store that maps onto SRL primitives
module start_token_srl_store #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) begin
      mem[0] <= din;
      for (int i = 0; i < DEPTH - 1; i++) mem[i+1] <= mem[i];
    end
  assign dout = mem[addr];
endmodule

// File: rtl/start_token_srl_fifo.sv
// start_token_srl_fifo: FWFT FIFO for start tokens built on a shift-register store
module start_token_srl_fifo
  import start_token_srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   count
);
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
  if (!depth_fits(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must be >= 1 and fit in 2**ADDR_WIDTH");
  end
  logic wr, rd;
  logic [ADDR_WIDTH:0] count_next;
  logic [ADDR_WIDTH-1:0] raddr;
  assign wr = if_write_ce & if_write & if_full_n;
  assign rd = if_read_ce & if_read & if_empty_n;
  // a simultaneous shift+retire leaves the oldest live token at the same address
  assign raddr = (DEPTH == 1) ? '0 : ADDR_WIDTH'(count - 1'b1);
  always_comb
    count_next = (wr & ~rd) ? count + 1'b1 : (rd & ~wr) ? count - 1'b1 : count;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      count      <= '0;
      if_full_n  <= 1'b1;
      if_empty_n <= 1'b0;
    end else begin
      count      <= count_next;
      if_full_n  <= count_next != FULL;
      if_empty_n <= count_next != '0;
    end
  start_token_srl_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH)
  ) u_store (
    .clk (ap_clk),
    .we  (wr),
    .addr(raddr),
    .din (if_din),
    .dout(if_dout)
  );
endmodule

// File: tb/tb_start_token_srl_fifo.sv
// tb_start_token_srl_fifo: directed checks on a DEPTH=2 and a DEPTH=4 instance
module tb_start_token_srl_fifo;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b1;
  logic full_n2, empty_n2, w_ce2, w2, r_ce2, r2, din2, dout2;
  logic [1:0] count2;
  logic full_n4, empty_n4, w_ce4, w4, r_ce4, r4;
  logic [7:0] din4, dout4;
  logic [2:0] count4;
  int checks = 0;
  int failures = 0;
  always #5 ap_clk = ~ap_clk;
  start_token_srl_fifo #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) dut2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .if_full_n(full_n2),
    .if_write_ce(w_ce2), .if_write(w2), .if_din(din2),
    .if_empty_n(empty_n2), .if_read_ce(r_ce2), .if_read(r2),
    .if_dout(dout2), .count(count2)
  );
  start_token_srl_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut4 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .if_full_n(full_n4),
    .if_write_ce(w_ce4), .if_write(w4), .if_din(din4),
    .if_empty_n(empty_n4), .if_read_ce(r_ce4), .if_read(r4),
    .if_dout(dout4), .count(count4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask
  initial begin
    {w_ce2, w2, r_ce2, r2, din2} = '0;
    {w_ce4, w4, r_ce4, r4} = '0;
    din4 = '0;
    #2 ap_rst_n = 1'b0;
    #1;
    chk("rst_full_n2", full_n2, 1);
    chk("rst_empty_n2", empty_n2, 0);
    chk("rst_count2", count2, 0);
    chk("rst_full_n4", full_n4, 1);
    chk("rst_empty_n4", empty_n4, 0);
    chk("rst_count4", count4, 0);
    #20 ap_rst_n = 1'b1;
    step();
    chk("idle_count2", count2, 0);
    chk("idle_empty_n2", empty_n2, 0);
    w_ce2 = 1; w2 = 1; din2 = 1;
    step();
    chk("w1_count2", count2, 1);
    chk("w1_empty_n2", empty_n2, 1);
    chk("w1_dout2", dout2, 1);
    din2 = 0;
    step();
    chk("w2_count2", count2, 2);
    chk("w2_full_n2", full_n2, 0);
    chk("w2_dout2", dout2, 1);
    din2 = 1;
    step();
    chk("w3_ignored_count2", count2, 2);
    chk("w3_ignored_dout2", dout2, 1);
    w2 = 0; r_ce2 = 1; r2 = 1;
    chk("rd1_dout2", dout2, 1);
    step();
    chk("rd1_count2", count2, 1);
    chk("rd1_full_n2", full_n2, 1);
    chk("rd2_dout2", dout2, 0);
    step();
    chk("rd2_count2", count2, 0);
    chk("rd2_empty_n2", empty_n2, 0);
    r2 = 0; w2 = 1; din2 = 1;
    step();
    din2 = 0;
    step();
    chk("refill_count2", count2, 2);
    din2 = 1; r2 = 1;
    chk("fullwr_rd_dout2", dout2, 1);
    step();
    chk("fullwr_count2", count2, 1);
    chk("fullwr_next_dout2", dout2, 0);
    chk("fullwr_full_n2", full_n2, 1);
    w2 = 0;
    step();
    chk("drain_count2", count2, 0);
    r2 = 0; w_ce2 = 0; w2 = 1;
    repeat (3) step();
    chk("wce_gate_count2", count2, 0);
    w_ce2 = 1; r2 = 1; din2 = 1;
    step();
    chk("empty_wr_rd_count2", count2, 1);
    chk("empty_wr_rd_empty_n2", empty_n2, 1);
    chk("empty_wr_rd_dout2", dout2, 1);
    w2 = 0; r_ce2 = 0;
    repeat (2) step();
    chk("rce_gate_count2", count2, 1);
    r2 = 0;
    w_ce4 = 1; w4 = 1; din4 = 8'hA1;
    step();
    din4 = 8'hB2;
    step();
    chk("ab_count4", count4, 2);
    chk("ab_dout4", dout4, 8'hA1);
    din4 = 8'hC3; r_ce4 = 1; r4 = 1;
    chk("mid_rd_dout4", dout4, 8'hA1);
    step();
    chk("mid_count4", count4, 2);
    chk("mid_next_dout4", dout4, 8'hB2);
    w4 = 0;
    step();
    chk("rdB_count4", count4, 1);
    chk("rdC_dout4", dout4, 8'hC3);
    step();
    chk("drain_empty_n4", empty_n4, 0);
    r4 = 0; w4 = 1; din4 = 8'h11;
    step();
    din4 = 8'h22;
    step();
    din4 = 8'h33;
    step();
    w4 = 0;
    chk("three_count4", count4, 3);
    chk("three_dout4", dout4, 8'h11);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("midrst_count4", count4, 0);
    chk("midrst_empty_n4", empty_n4, 0);
    chk("midrst_full_n4", full_n4, 1);
    #2 ap_rst_n = 1'b1;
    w4 = 1; din4 = 8'h44;
    step();
    w4 = 0;
    chk("postrst_count4", count4, 1);
    chk("postrst_empty_n4", empty_n4, 1);
    chk("postrst_dout4", dout4, 8'h44);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
